// File: rtl/spmc_dimmer_array.sv
// SpartanMC multi-channel PWM dimmer: per-channel debounced switches, ramp/host modes, sticky change flags.
// Optional DIMMER_GAMMA_EN: squares the level into a registered gamma duty; otherwise duty tracks the level.
module spmc_dimmer_chan #(
  parameter int LEVEL_WIDTH     = 10,
  parameter int AUTO_STEP       = 55,
  parameter int AUTO_PERIOD     = 100,
  parameter int SW_STEP         = 11,
  parameter int SW_PERIOD       = 5,
  parameter int DOWN_STEP       = 11,
  parameter int DEBOUNCE_CYCLES = 131072
) (
  input  logic                   i_clk,
  input  logic                   i_clr,
  input  logic                   i_en,
  input  logic                   i_tick,
  input  logic                   i_wrap,
  input  logic                   i_wr_val,
  input  logic [LEVEL_WIDTH-1:0] i_wdata,
  input  logic [LEVEL_WIDTH-1:0] i_pcnt,
  input  logic [1:0]             i_mode,
  input  logic                   i_up,
  input  logic                   i_dn,
  output logic [LEVEL_WIDTH-1:0] o_lvl,
  output logic                   o_chg,
  output logic                   o_led
);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW1 = LEVEL_WIDTH + 1;

  logic [1:0]                   r_s1, r_s2, r_db, w_acc;
  logic [1:0][DBW-1:0]          r_dbc;
  logic [15:0]                  r_per, w_per_nx, w_prd;
  logic [LEVEL_WIDTH-1:0]       r_lvl, w_nx, r_duty, w_src;
  logic [LW1-1:0]               w_step, w_sum;
  logic                         w_dn_rise, w_ramp, w_add;

  // bit0 = up, bit1 = down; a level is accepted once it has differed for DEBOUNCE_CYCLES
  always_comb begin
    for (int j = 0; j < 2; j++)
      w_acc[j] = (r_s2[j] != r_db[j]) && (r_dbc[j] == DBW'(DEBOUNCE_CYCLES - 1));
  end
  assign w_dn_rise = w_acc[1] & r_s2[1];

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_s1 <= '0; r_s2 <= '0; r_db <= '0; r_dbc <= '0;
    end else begin
      r_s1 <= {i_dn, i_up};
      r_s2 <= r_s1;
      for (int j = 0; j < 2; j++) begin
        if (w_acc[j]) begin
          r_db[j]  <= r_s2[j];
          r_dbc[j] <= '0;
        end else if (r_s2[j] != r_db[j]) r_dbc[j] <= r_dbc[j] + 1'b1;
        else r_dbc[j] <= '0;
      end
    end
  end

  always_comb begin
    w_ramp   = (i_mode == 2'd1) || (i_mode == 2'd2 && r_db[0]);
    w_prd    = (i_mode == 2'd1) ? 16'(AUTO_PERIOD - 1) : 16'(SW_PERIOD - 1);
    w_step   = (i_mode == 2'd1) ? LW1'(AUTO_STEP) : LW1'(SW_STEP);
    w_add    = i_tick && w_ramp && (r_per == w_prd);
    w_sum    = {1'b0, r_lvl} + w_step;
    w_per_nx = r_per;
    w_nx     = r_lvl;
    // period counter idles at 0 until ramping, so a switch period counts from the press
    if (!i_en || !w_ramp || w_dn_rise) w_per_nx = '0;
    else if (i_tick) w_per_nx = w_add ? 16'd0 : r_per + 16'd1;
    if (!i_en) w_nx = '0;
    else if (i_wr_val) w_nx = i_wdata;
    else if (i_mode == 2'd0) w_nx = '0;
    else if (w_dn_rise && (i_mode == 2'd1 || i_mode == 2'd2))
      w_nx = ({1'b0, r_lvl} < LW1'(DOWN_STEP)) ? '0 : r_lvl - LEVEL_WIDTH'(DOWN_STEP);
    else if (w_add) w_nx = w_sum[LEVEL_WIDTH] ? '1 : w_sum[LEVEL_WIDTH-1:0];
  end

`ifdef DIMMER_GAMMA_EN
  logic [2*LEVEL_WIDTH-1:0] w_sq;
  logic [LEVEL_WIDTH-1:0]   r_gam;
  logic                     w_unused_sq;
  assign w_sq        = r_lvl * r_lvl;
  assign w_unused_sq = ^w_sq[LEVEL_WIDTH-1:0];
  // full-scale level maps to full-on, since the square alone never reaches it
  always_ff @(posedge i_clk) begin
    if (i_clr) r_gam <= '0;
    else r_gam <= (&r_lvl) ? '1 : w_sq[2*LEVEL_WIDTH-1:LEVEL_WIDTH];
  end
  assign w_src = r_gam;
`else
  assign w_src = r_lvl;
`endif

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_lvl <= '0; r_per <= '0; r_duty <= '0;
    end else begin
      r_lvl <= w_nx;
      r_per <= w_per_nx;
      if (!i_en) r_duty <= '0;
      else if (i_wrap) r_duty <= w_src;
    end
  end

  assign o_lvl = r_lvl;
  assign o_chg = (w_nx != r_lvl);
  assign o_led = i_en && (i_pcnt < r_duty);
endmodule

module spmc_dimmer_array #(
  parameter logic [9:0] BASE_ADR  = 10'h0,
  parameter int CLOCK_FREQUENCY   = 16000000,
  parameter int NUM_CHANNELS      = 2,
  parameter int LEVEL_WIDTH       = 10,
  parameter int PWM_FREQ          = 1000,
  parameter int AUTO_STEP         = 55,
  parameter int AUTO_PERIOD       = 100,
  parameter int SW_STEP           = 11,
  parameter int SW_PERIOD         = 5,
  parameter int DOWN_STEP         = 11,
  parameter int DEBOUNCE_CYCLES   = 131072
) (
  input  logic                    clk_peri,
  input  logic                    reset,
  input  logic [17:0]             do_peri,
  output logic [17:0]             di_peri,
  input  logic [9:0]              addr_peri,
  input  logic                    access_peri,
  input  logic                    wr_peri,
  input  logic [NUM_CHANNELS-1:0] switch_up,
  input  logic [NUM_CHANNELS-1:0] switch_down,
  output logic [NUM_CHANNELS-1:0] led_pwm,
  output logic                    pwm_value_changed
);
  localparam int NREG  = 3 + 2 * NUM_CHANNELS;
  localparam int TDIV  = CLOCK_FREQUENCY / 100;
  localparam int TW    = $clog2(TDIV + 1);
  localparam int PRE_R = CLOCK_FREQUENCY / (PWM_FREQ * ((1 << LEVEL_WIDTH) - 1));
  localparam int PRE   = (PRE_R < 1) ? 1 : PRE_R;
  localparam int PW    = $clog2(PRE + 1);
  localparam logic [LEVEL_WIDTH-1:0] PTOP = LEVEL_WIDTH'((1 << LEVEL_WIDTH) - 2);

  logic [9:0]                               w_idx;
  logic                                     w_wr, w_rd, w_clr, w_tick, w_wrap, w_exp, w_unused;
  logic [17:0]                              w_rdata, r_di;
  logic [NUM_CHANNELS-1:0]                  w_chg, w_wr_val, r_flags;
  logic [NUM_CHANNELS-1:0][LEVEL_WIDTH-1:0] w_lvl;
  logic [NUM_CHANNELS-1:0][1:0]             r_mode;
  logic                                     r_en, r_pvc;
  logic [7:0]                               r_ivl, r_scnt;
  logic [TW-1:0]                            r_tcnt;
  logic [PW-1:0]                            r_pre;
  logic [LEVEL_WIDTH-1:0]                   r_pcnt;

  assign w_idx    = addr_peri - BASE_ADR;
  assign w_wr     = access_peri && wr_peri && (w_idx < 10'(NREG));
  assign w_rd     = access_peri && !wr_peri && (w_idx < 10'(NREG));
  assign w_clr    = reset || (w_wr && w_idx == 10'd0 && do_peri[1]);
  assign w_tick   = r_en && (r_tcnt == TW'(TDIV - 1));
  assign w_wrap   = r_en && (r_pre == PW'(PRE - 1)) && (r_pcnt == PTOP);
  assign w_exp    = w_tick && (r_ivl != 8'd0) && (r_scnt == r_ivl - 8'd1);
  assign w_unused = ^do_peri;

  always_comb begin
    w_rdata  = '0;
    w_wr_val = '0;
    case (w_idx)
      10'd0:   w_rdata[0] = r_en;
      10'd1:   w_rdata[NUM_CHANNELS-1:0] = r_flags;
      10'd2:   w_rdata[7:0] = r_ivl;
      default: ;
    endcase
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (w_idx == 10'(3 + 2 * k)) w_rdata[1:0] = r_mode[k];
      if (w_idx == 10'(4 + 2 * k)) w_rdata[LEVEL_WIDTH-1:0] = w_lvl[k];
      w_wr_val[k] = w_wr && r_en && (w_idx == 10'(4 + 2 * k));
    end
  end

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
    spmc_dimmer_chan #(
      .LEVEL_WIDTH(LEVEL_WIDTH), .AUTO_STEP(AUTO_STEP), .AUTO_PERIOD(AUTO_PERIOD),
      .SW_STEP(SW_STEP), .SW_PERIOD(SW_PERIOD), .DOWN_STEP(DOWN_STEP),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .i_clk(clk_peri), .i_clr(w_clr), .i_en(r_en), .i_tick(w_tick), .i_wrap(w_wrap),
      .i_wr_val(w_wr_val[k]), .i_wdata(do_peri[LEVEL_WIDTH-1:0]), .i_pcnt(r_pcnt),
      .i_mode(r_mode[k]), .i_up(switch_up[k]), .i_dn(switch_down[k]),
      .o_lvl(w_lvl[k]), .o_chg(w_chg[k]), .o_led(led_pwm[k])
    );
  end

  always_ff @(posedge clk_peri) begin
    if (w_clr) begin
      r_en <= 1'b0; r_ivl <= 8'd10; r_mode <= '0; r_flags <= '0; r_di <= '0;
      r_pvc <= 1'b0; r_tcnt <= '0; r_scnt <= '0; r_pre <= '0; r_pcnt <= '0;
    end else begin
      if (w_wr && w_idx == 10'd0) r_en <= do_peri[0];
      if (w_wr && w_idx == 10'd2) r_ivl <= do_peri[7:0];
      for (int k = 0; k < NUM_CHANNELS; k++)
        if (w_wr && w_idx == 10'(3 + 2 * k)) r_mode[k] <= do_peri[1:0];
      // a change landing in the same cycle as the read survives the clear
      r_flags <= ((w_rd && w_idx == 10'd1) ? '0 : r_flags) | w_chg;
      r_di    <= w_rd ? w_rdata : 18'd0;
      r_pvc   <= (|w_chg) || w_exp;
      r_tcnt  <= (!r_en || w_tick) ? '0 : r_tcnt + 1'b1;
      if (!r_en || (|w_chg) || (w_wr && w_idx == 10'd2) || w_exp) r_scnt <= '0;
      else if (w_tick) r_scnt <= r_scnt + 8'd1;
      if (!r_en) begin
        r_pre <= '0; r_pcnt <= '0;
      end else if (r_pre == PW'(PRE - 1)) begin
        r_pre  <= '0;
        r_pcnt <= (r_pcnt == PTOP) ? '0 : r_pcnt + 1'b1;
      end else r_pre <= r_pre + 1'b1;
    end
  end

  assign di_peri           = r_di;
  assign pwm_value_changed = r_pvc;
endmodule
